// File: rtl/ps2_keyboard_if.sv
// PS/2 keyboard pin and CPU read-port bundle.
// master drives the pins and read strobe; slave is the receiver.
interface ps2_keyboard_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic       io_rdn;
    logic       ready;
    logic [7:0] key_data;
    logic       overflow;
    logic       frame_err;

    modport master (
        output ps2_clk, ps2_data, io_rdn,
        input  ready, key_data, overflow, frame_err
    );

    modport slave (
        input  ps2_clk, ps2_data, io_rdn,
        output ready, key_data, overflow, frame_err
    );
endinterface

// File: rtl/ps2_keyboard.sv
// PS/2 keyboard receiver: synchronises the pins, checks framing and odd
// parity, and queues scan codes in a small FIFO popped by the CPU read.
module ps2_keyboard #(
    parameter int FIFO_AW = 3,
    parameter int TIMEOUT = 50000
) (
    input logic         clk,
    input logic         rst,
    ps2_keyboard_if.slave bus
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int TW    = $clog2(TIMEOUT + 1);

    // [0],[1] synchroniser stages, [2] delayed synced clock
    logic [2:0]       clk_sync;
    logic [1:0]       dat_sync;
    logic             rdn_q;
    logic [3:0]       bit_cnt, bit_cnt_n;
    logic [9:0]       shreg, shreg_n;
    logic [TW-1:0]    tcnt, tcnt_n;
    logic [FIFO_AW:0] wr_ptr, rd_ptr;
    logic [7:0]       mem [DEPTH];
    logic             overflow_r, frame_err_r;

    logic        fe, done, good, timeout;
    logic        empty, full, pop, push, drop;
    logic [10:0] frame;

    assign fe    = clk_sync[2] & ~clk_sync[1];
    assign frame = {dat_sync[1], shreg};
    assign done  = fe && (bit_cnt == 4'd10);
    assign good  = ~frame[0] & frame[10] & (^frame[9:1]);

    assign timeout = !fe && (bit_cnt != 4'd0) &&
                     (tcnt == TW'(TIMEOUT - 1));

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                   (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
    assign pop   = ~rdn_q & bus.io_rdn & ~empty;

    // a pop in the same cycle frees the slot for a full-FIFO push
    assign push  = done & good & (~full | pop);
    assign drop  = done & good & full & ~pop;

    always_comb begin
        shreg_n   = shreg;
        bit_cnt_n = bit_cnt;
        tcnt_n    = tcnt + TW'(1);
        if (fe) begin
            shreg_n   = frame[10:1];
            bit_cnt_n = done ? 4'd0 : bit_cnt + 4'd1;
            tcnt_n    = '0;
        end else if (bit_cnt == 4'd0) begin
            tcnt_n = '0;
        end else if (timeout) begin
            bit_cnt_n = 4'd0;
            tcnt_n    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync    <= 3'b111;
            dat_sync    <= 2'b11;
            rdn_q       <= 1'b1;
            bit_cnt     <= 4'd0;
            shreg       <= '0;
            tcnt        <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            overflow_r  <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            clk_sync    <= {clk_sync[1:0], bus.ps2_clk};
            dat_sync    <= {dat_sync[0], bus.ps2_data};
            rdn_q       <= bus.io_rdn;
            bit_cnt     <= bit_cnt_n;
            shreg       <= shreg_n;
            tcnt        <= tcnt_n;
            frame_err_r <= (done & ~good) | timeout;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (pop)
                overflow_r <= 1'b0;
            else if (drop)
                overflow_r <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push)
            mem[wr_ptr[FIFO_AW-1:0]] <= frame[8:1];
    end

    assign bus.ready     = ~empty;
    assign bus.key_data  = empty ? 8'h00 : mem[rd_ptr[FIFO_AW-1:0]];
    assign bus.overflow  = overflow_r;
    assign bus.frame_err = frame_err_r;
endmodule
